// File: rtl/binpool_stream.sv
// Captures one binarized feature map, applies 2x2 stride-2 OR pooling and
// streams the pooled map out CPB channels per valid/ready beat.

module binpool_chan #(
    parameter int H = 8,
    parameter int W = 8
) (
    input  logic [0:H*W-1]           i_ch,
    output logic [0:(H/2)*(W/2)-1]   o_pool
);
    for (genvar pr = 0; pr < H/2; pr++) begin : g_row
        for (genvar pc = 0; pc < W/2; pc++) begin : g_col
            assign o_pool[pr*(W/2)+pc] = i_ch[(2*pr)*W + 2*pc]   | i_ch[(2*pr)*W + 2*pc+1] |
                                         i_ch[(2*pr+1)*W + 2*pc] | i_ch[(2*pr+1)*W + 2*pc+1];
        end
    end
endmodule

module binpool_stream #(
    parameter int NCH = 60,
    parameter int H   = 8,
    parameter int W   = 8,
    parameter int CPB = 1,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [0:NCH*H*W-1]             in_map,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [0:CPB*(H/2)*(W/2)-1]     out_data,
    output logic [CW-1:0]                  out_chan,
    output logic                           out_last,
    output logic                           frame_done
);
    localparam int HW    = H*W;
    localparam int PHW   = (H/2)*(W/2);
    localparam int NBEAT = NCH/CPB;
    localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int PW    = $clog2(NCH*PHW) > 0 ? $clog2(NCH*PHW) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 r_state, w_state_nxt;
    logic [0:NCH*HW-1]      r_map;
    logic [BW-1:0]          r_beat;
    logic                   r_frame_done;
    logic [0:NCH*PHW-1]     w_pool;
    logic [PW-1:0]          w_base;
    logic                   w_hs_out, w_last, w_cap;

    // Every channel is pooled in parallel; the beat counter only selects.
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        binpool_chan #(.H(H), .W(W)) u_chan (
            .i_ch   (r_map[c*HW +: HW]),
            .o_pool (w_pool[c*PHW +: PHW])
        );
    end

    assign w_base     = PW'(r_beat) * PW'(CPB*PHW);
    assign w_last     = (r_beat == BW'(NBEAT-1));
    assign w_hs_out   = out_valid & out_ready;
    assign in_ready   = (r_state == IDLE) | (w_hs_out & w_last);
    assign w_cap      = in_valid & in_ready;

    assign out_valid  = (r_state == STREAM);
    assign out_last   = out_valid & w_last;
    assign out_data   = out_valid ? w_pool[w_base +: CPB*PHW] : '0;
    assign out_chan   = CW'(r_beat) * CW'(CPB);
    assign frame_done = r_frame_done;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_nxt = STREAM;
            STREAM:  if (w_hs_out && w_last && !in_valid) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_map        <= '0;
            r_beat       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_hs_out & w_last;
            if (w_cap)
                r_map <= in_map;
            // A capture on the last accepted beat restarts the count with no bubble.
            if (w_cap)
                r_beat <= '0;
            else if (w_hs_out && !w_last)
                r_beat <= r_beat + 1'b1;
        end
    end
endmodule
